// File: rtl/trust_pkg.sv
// Shared types for the trust-based output port scheduler.
// Direction codes, FSM state encoding and default trust width.
package trust_pkg;

  localparam int TRUST_W_DEF = 4;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT_ACK
  } state_e;

endpackage

// File: rtl/trust_select.sv
// Picks the eligible direction with the highest trust; ties resolved
// round-robin starting at ptr. mask bit3 = N, trust index 0 = N.
module trust_select
  import trust_pkg::*;
#(
  parameter int TRUST_W = TRUST_W_DEF
) (
  input  logic [3:0]         mask,
  input  logic [TRUST_W-1:0] trust_n,
  input  logic [TRUST_W-1:0] trust_s,
  input  logic [TRUST_W-1:0] trust_e,
  input  logic [TRUST_W-1:0] trust_w,
  input  logic [TRUST_W-1:0] trust_min,
  input  logic [1:0]         ptr,
  output logic               found,
  output logic [1:0]         dir
);

  logic [TRUST_W-1:0] tr [4];
  logic [TRUST_W-1:0] best;
  logic [3:0]         elig;
  logic [1:0]         d;

  always_comb begin
    tr[0] = trust_n;
    tr[1] = trust_s;
    tr[2] = trust_e;
    tr[3] = trust_w;
    for (int i = 0; i < 4; i++) begin
      elig[i] = mask[3-i] && (tr[i] >= trust_min);
    end
  end

  // Strict '>' keeps the first candidate in rr order on a tie.
  always_comb begin
    found = 1'b0;
    dir   = ptr;
    best  = '0;
    d     = ptr;
    for (int i = 0; i < 4; i++) begin
      d = ptr + 2'(i);
      if (elig[d] && (!found || tr[d] > best)) begin
        found = 1'b1;
        best  = tr[d];
        dir   = d;
      end
    end
  end

endmodule

// File: rtl/trust_port_scheduler.sv
// Output-stage sequencer: one packet in flight, trust debit/credit/penalty.
// Optional TRUST_RECOVER_EN adds a periodic trust recovery tick.
module trust_port_scheduler
  import trust_pkg::*;
#(
  parameter int TRUST_W        = TRUST_W_DEF,
  parameter int TRUST_INIT     = 8,
  parameter int TRUST_MIN      = 2,
  parameter int DELTA          = 1,
  parameter int ACK_TIMEOUT    = 16,
  parameter int RECOVER_PERIOD = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pkt_valid,
  input  logic [3:0]             pkt_dir_mask,
  output logic                   pkt_ready,
  output logic                   grant_valid,
  output logic [1:0]             grant_dir,
  input  logic                   grant_ready,
  input  logic                   ack_valid,
  input  logic [1:0]             ack_dir,
  output logic                   drop,
  output logic                   timeout,
  output logic [4*TRUST_W-1:0]   trust_levels
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int SW    = TRUST_W + 3;
  localparam logic signed [SW-1:0] MAX_S = SW'((2 ** TRUST_W) - 1);
  localparam logic signed [SW-1:0] DEL_S = SW'(DELTA);

  state_e             state_q, state_d;
  logic [3:0]         mask_q, mask_d;
  logic [1:0]         dir_q, dir_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TRUST_W-1:0] trust_q [4];
  logic [TRUST_W-1:0] trust_d [4];

  logic               sel_found;
  logic [1:0]         sel_dir;
  logic               hs, ack_hit, to_hit, rec_tick;
  logic signed [SW-1:0] sum;

  trust_select #(
    .TRUST_W (TRUST_W)
  ) u_sel (
    .mask      (mask_q),
    .trust_n   (trust_q[0]),
    .trust_s   (trust_q[1]),
    .trust_e   (trust_q[2]),
    .trust_w   (trust_q[3]),
    .trust_min (TRUST_W'(TRUST_MIN)),
    .ptr       (ptr_q),
    .found     (sel_found),
    .dir       (sel_dir)
  );

  assign hs      = (state_q == ST_ISSUE) && grant_ready;
  assign ack_hit = (state_q == ST_WAIT_ACK) && ack_valid
                && (ack_dir == dir_q);
  assign to_hit  = (state_q == ST_WAIT_ACK) && !ack_hit
                && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

`ifdef TRUST_RECOVER_EN
  localparam int RW = (RECOVER_PERIOD > 2) ? $clog2(RECOVER_PERIOD) : 1;
  logic [RW-1:0] rec_q, rec_d;

  assign rec_tick = (rec_q == RW'(RECOVER_PERIOD - 1));

  always_comb begin
    rec_d = rec_tick ? '0 : rec_q + RW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rec_q <= '0;
    else       rec_q <= rec_d;
  end
`else
  assign rec_tick = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (pkt_valid) state_d = ST_SELECT;
      ST_SELECT:   state_d = sel_found ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:    if (grant_ready) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (ack_hit || to_hit) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pkt_ready   = (state_q == ST_IDLE) && !reset;
    grant_valid = (state_q == ST_ISSUE);
    grant_dir   = dir_q;
    drop        = (state_q == ST_SELECT) && !sel_found;
    timeout     = to_hit;
  end

  always_comb begin
    mask_d = mask_q;
    dir_d  = dir_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (state_q == ST_IDLE && pkt_valid) mask_d = pkt_dir_mask;
    if (state_q == ST_SELECT && sel_found) dir_d = sel_dir;
    if (hs) begin
      ptr_d = dir_q + 2'd1;
      cnt_d = '0;
    end else if (state_q == ST_WAIT_ACK) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // All same-cycle contributions are summed, then clamped once.
  always_comb begin
    sum = '0;
    for (int d = 0; d < 4; d++) begin
      sum = SW'(trust_q[d]);
      if (dir_q == 2'(d)) begin
        if (hs)      sum = sum - DEL_S;
        if (ack_hit) sum = sum + DEL_S;
        if (to_hit)  sum = sum - DEL_S;
      end
      if (rec_tick && trust_q[d] < TRUST_W'(TRUST_INIT))
        sum = sum + DEL_S;
      if (sum < 0)          trust_d[d] = '0;
      else if (sum > MAX_S) trust_d[d] = MAX_S[TRUST_W-1:0];
      else                  trust_d[d] = sum[TRUST_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      dir_q  <= DIR_N;
      ptr_q  <= DIR_N;
      cnt_q  <= '0;
      for (int d = 0; d < 4; d++) trust_q[d] <= TRUST_W'(TRUST_INIT);
    end else begin
      mask_q <= mask_d;
      dir_q  <= dir_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      for (int d = 0; d < 4; d++) trust_q[d] <= trust_d[d];
    end
  end

  assign trust_levels = {trust_q[0], trust_q[1], trust_q[2], trust_q[3]};

endmodule

// File: doc/trust_port_scheduler.md
# trust_port_scheduler

Sequencing controller for the trust-based router's output stage. It accepts one packet at a time with a mask of productive output directions. It grants the eligible direction with the highest trust level, then holds the packet outstanding until an acknowledgment arrives or a timeout expires. It owns the per-direction trust counters: a grant is a debit, an ack is a credit, a timeout is a penalty. It sits between the input buffer and the crossbar select logic.

## Interface
- TRUST_W, 4: trust counter width; counters saturate at 0 and 2^TRUST_W-1.
- TRUST_INIT, 8: reset value of every trust counter.
- TRUST_MIN, 2: a direction is eligible only if trust ≥ TRUST_MIN.
- DELTA, 1: step for debit, credit and penalty.
- ACK_TIMEOUT, 16: cycles in WAIT_ACK before a timeout.
- RECOVER_PERIOD, 64: recovery tick interval; used only with TRUST_RECOVER_EN.

Ports:
- clk  in  1  single clock; rising edge.
- reset  in  1  asynchronous, active-high.
- pkt_valid  in  1  packet pending at the input buffer head.
- pkt_dir_mask  in  4  candidate directions {N,S,E,W}, bit3=N.
- pkt_ready  out  1  packet accepted this cycle.
- grant_valid  out  1  grant request to the crossbar.
- grant_dir  out  2  granted direction: 00=N, 01=S, 10=E, 11=W.
- grant_ready  in  1  crossbar took the packet.
- ack_valid  in  1  acknowledgment received.
- ack_dir  in  2  direction the ack refers to.
- drop  out  1  one-cycle pulse: packet accepted, but no eligible direction.
- timeout  out  1  one-cycle pulse: ack window expired.
- trust_levels  out  4*TRUST_W  {trust_N, trust_S, trust_E, trust_W}.

## Operation
- FSM states: IDLE, SELECT, ISSUE, WAIT_ACK.
- IDLE:
  - pkt_ready=1.
  - On pkt_valid, latch pkt_dir_mask and go to SELECT.
- SELECT:
  - eligible = mask & (trust ≥ TRUST_MIN).
  - If eligible is empty: pulse drop, go to IDLE.
  - Otherwise pick the highest trust among eligible directions.
  - Ties are broken round-robin, starting at the direction after the last granted one (pointer resets to N).
  - Register grant_dir, go to ISSUE.
- ISSUE:
  - grant_valid=1 and grant_dir held stable until grant_ready.
  - On the handshake: trust[dir] -= DELTA, advance the round-robin pointer, clear the ack counter, go to WAIT_ACK.
- WAIT_ACK:
  - Ack counter increments every cycle.
  - ack_valid with ack_dir==grant_dir: trust[dir] += DELTA, go to IDLE.
  - Counter reaching ACK_TIMEOUT-1 with no matching ack: trust[dir] -= DELTA, pulse timeout, go to IDLE.
- Boundary rules:
  - An ack and the timeout in the same cycle: the ack wins.
  - Non-matching acks, and any ack outside WAIT_ACK, are ignored.
  - All trust arithmetic saturates: no wrap at 0 or at max.
  - Several updates to one counter in the same cycle are summed first, then saturated once.
  - pkt_dir_mask==0 gives drop.
- Reset mid-operation:
  - Returns to IDLE immediately.
  - Any outstanding packet is forgotten; trust returns to TRUST_INIT.

## Timing
- Values during reset: grant_valid=0, drop=0, timeout=0, state=IDLE, trust_levels={4{TRUST_INIT}}, pkt_ready=0; pkt_ready rises on the first cycle after reset is released.
- Grant latency: accept at cycle 0, SELECT at cycle 1, grant_valid from cycle 2.
- Throughput: at most one packet in flight. Minimum accept-to-accept interval is 4 cycles (ack arriving the cycle after the grant).
- Trust updates become visible on trust_levels the cycle after the triggering event.
- drop pulses in the SELECT cycle; timeout pulses in the cycle WAIT_ACK is left.

## Configuration
- TRUST_RECOVER_EN defined:
  - A free-running counter ticks every RECOVER_PERIOD cycles.
  - On each tick, every counter below TRUST_INIT gains +DELTA, so excluded directions return to eligibility.
  - The tick adds into the same-cycle update sum.
- TRUST_RECOVER_EN undefined: no recovery counter; trust changes only on grant, ack and timeout.

## Structure
- Package trust_pkg: direction encoding constants (DIR_N..DIR_W), FSM state typedef, trust width default.
- Sub-module trust_select:
  - Combinational.
  - Inputs: mask, four trust values, TRUST_MIN, round-robin pointer.
  - Outputs: found, dir.

## Test plan
- Reset, then a packet with mask=1111 and all trust 8 → grant_dir=N at cycle 2; ack N → trust_levels returns to 8,8,8,8.
- Trust {5,9,9,3}, mask=0111 → S granted. Repeat with ties → S and E alternate round-robin.
- No ack for 16 cycles after a grant on E from 8 → timeout pulse; trust_E=6.
- Trust_W=1 and mask=0001 → drop pulse in the SELECT cycle, no grant_valid, FSM back in IDLE.
- Ack for W while waiting on N → ignored; ack N and timeout in the same cycle → trust_N restored, no timeout pulse.
- With TRUST_RECOVER_EN, trust_W=1 → reaches 2 after one RECOVER_PERIOD and is eligible again. Reset asserted during WAIT_ACK → outputs reset, trust=8.
